// File: rtl/descrambler_if.sv
// RX lane word bus between the block aligner and the descrambler, plus descrambler status outputs.
// slave: descrambler side; master: upstream driver / observer side.
interface descrambler_if #(
    parameter int W = 64
);
    logic [W-1:0] DATA_IN;
    logic [1:0]   HEADER_IN;
    logic         DATA_IN_VALID;
    logic         PASSTHROUGH;
    logic [W-1:0] DATA_OUT;
    logic [1:0]   HEADER_OUT;
    logic         DATA_OUT_VALID;
    logic         CTRL_WORD_OUT;
    logic         STATE_MISMATCH;
    logic         SCRAMBLER_LOCKED;

    modport slave (
        input  DATA_IN, HEADER_IN, DATA_IN_VALID, PASSTHROUGH,
        output DATA_OUT, HEADER_OUT, DATA_OUT_VALID, CTRL_WORD_OUT, STATE_MISMATCH, SCRAMBLER_LOCKED
    );

    modport master (
        output DATA_IN, HEADER_IN, DATA_IN_VALID, PASSTHROUGH,
        input  DATA_OUT, HEADER_OUT, DATA_OUT_VALID, CTRL_WORD_OUT, STATE_MISMATCH, SCRAMBLER_LOCKED
    );
endinterface

// File: rtl/descrambler.sv
// x^58+x^39+1 self-synchronous descrambler with sync/state word passthrough and lock tracking; 1-cycle latency.
// No backpressure: a word may arrive every cycle and is always accepted.
module descrambler #(
    parameter int          RX_DATA_WIDTH = 64,
    parameter logic [63:0] SYNC_WORD     = 64'h78f678f678f678f6,
    parameter int          LOCK_COUNT    = 4,
    parameter int          LOSS_COUNT    = 3
) (
    input  logic         USER_CLK,
    input  logic         SYSTEM_RESET_N,
    descrambler_if.slave bus
);
    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_t;

    localparam logic [4:0] LOCK_TGT     = 5'(LOCK_COUNT);
    localparam logic [4:0] LOSS_TGT     = 5'(LOSS_COUNT);
    localparam logic [5:0] STATE_PREFIX = 6'b001010;

    lock_state_t              r_state, w_state_nxt;
    logic [57:0]              r_s, w_s_nxt, w_desc_s;
    logic                     r_expect, w_expect_nxt;
    logic [3:0]               r_good, w_good_nxt, r_bad, w_bad_nxt;
    logic [3:0]               w_good_sat, w_bad_sat;
    logic [4:0]               w_good_inc, w_bad_inc;
    logic [RX_DATA_WIDTH-1:0] r_data, w_data_nxt, w_desc_data;
    logic [1:0]               r_hdr;
    logic                     r_vld, r_ctrl, w_ctrl_nxt, r_mm, w_mm_nxt;
    logic                     w_is_sync, w_pass;

    assign w_is_sync  = (bus.DATA_IN == SYNC_WORD) && (bus.HEADER_IN == 2'b10);
    assign w_pass     = (bus.DATA_IN[63:58] == STATE_PREFIX) && (bus.DATA_IN[57:0] == r_s);
    assign w_good_inc = {1'b0, r_good} + 5'd1;
    assign w_bad_inc  = {1'b0, r_bad} + 5'd1;
    assign w_good_sat = (r_good == 4'hF) ? r_good : w_good_inc[3:0];
    assign w_bad_sat  = (r_bad == 4'hF) ? r_bad : w_bad_inc[3:0];

    // Bit 0 is first on the wire; the received (scrambled) bit feeds the shift register.
    always_comb begin : descramble
        logic [57:0] v_s;
        v_s         = r_s;
        w_desc_data = '0;
        for (int i = 0; i < RX_DATA_WIDTH; i++) begin
            w_desc_data[i] = bus.DATA_IN[i] ^ v_s[38] ^ v_s[57];
            v_s            = {v_s[56:0], bus.DATA_IN[i]};
        end
        w_desc_s = v_s;
    end

    always_comb begin : next_state
        w_state_nxt  = r_state;
        w_s_nxt      = r_s;
        w_expect_nxt = r_expect;
        w_good_nxt   = r_good;
        w_bad_nxt    = r_bad;
        w_data_nxt   = r_data;
        w_ctrl_nxt   = 1'b0;
        w_mm_nxt     = 1'b0;
        if (bus.PASSTHROUGH) begin
            w_data_nxt   = bus.DATA_IN;
            w_s_nxt      = '1;
            w_expect_nxt = 1'b0;
            w_state_nxt  = HUNT;
            w_good_nxt   = '0;
            w_bad_nxt    = '0;
        end else if (bus.DATA_IN_VALID) begin
            if (r_expect) begin
                // State word: S is reloaded even on a failed check so the next period can resync.
                w_data_nxt   = bus.DATA_IN;
                w_ctrl_nxt   = 1'b1;
                w_mm_nxt     = ~w_pass;
                w_s_nxt      = bus.DATA_IN[57:0];
                w_expect_nxt = 1'b0;
                case (r_state)
                    HUNT: begin
                        if (w_pass) begin
                            w_good_nxt = w_good_sat;
                            if (w_good_inc == LOCK_TGT) begin
                                w_state_nxt = LOCKED;
                                w_bad_nxt   = '0;
                            end
                        end else begin
                            w_good_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (w_pass) begin
                            w_bad_nxt = '0;
                        end else begin
                            w_bad_nxt = w_bad_sat;
                            if (w_bad_inc == LOSS_TGT) begin
                                w_state_nxt = HUNT;
                                w_good_nxt  = '0;
                            end
                        end
                    end
                    default: w_state_nxt = HUNT;
                endcase
            end else if (w_is_sync) begin
                w_data_nxt   = bus.DATA_IN;
                w_ctrl_nxt   = 1'b1;
                w_expect_nxt = 1'b1;
            end else begin
                w_data_nxt = w_desc_data;
                w_s_nxt    = w_desc_s;
            end
        end
    end

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            r_state <= HUNT;
            r_good  <= '0;
            r_bad   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
            r_bad   <= w_bad_nxt;
        end
    end

    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            r_s      <= '1;
            r_expect <= 1'b0;
            r_data   <= '0;
            r_hdr    <= 2'b00;
            r_vld    <= 1'b0;
            r_ctrl   <= 1'b0;
            r_mm     <= 1'b0;
        end else begin
            r_s      <= w_s_nxt;
            r_expect <= w_expect_nxt;
            r_data   <= w_data_nxt;
            r_hdr    <= bus.HEADER_IN;
            r_vld    <= bus.DATA_IN_VALID;
            r_ctrl   <= w_ctrl_nxt;
            r_mm     <= w_mm_nxt;
        end
    end

    assign bus.DATA_OUT         = r_data;
    assign bus.HEADER_OUT       = r_hdr;
    assign bus.DATA_OUT_VALID   = r_vld;
    assign bus.CTRL_WORD_OUT    = r_ctrl;
    assign bus.STATE_MISMATCH   = r_mm;
    assign bus.SCRAMBLER_LOCKED = (r_state == LOCKED);
endmodule

// File: tb/tb_descrambler.sv
// Randomized loopback bench: a behavioural TX scrambler feeds the descrambler, and a word-level RX model predicts every output.
module tb_descrambler;
    localparam logic [63:0] SYNC   = 64'h78f678f678f678f6;
    localparam int          LOCK_N = 4;
    localparam int          LOSS_N = 3;

    logic USER_CLK       = 1'b0;
    logic SYSTEM_RESET_N = 1'b0;
    always #5 USER_CLK = ~USER_CLK;

    descrambler_if #(.W(64)) bus ();

    descrambler #(
        .RX_DATA_WIDTH(64),
        .SYNC_WORD    (SYNC),
        .LOCK_COUNT   (LOCK_N),
        .LOSS_COUNT   (LOSS_N)
    ) dut (
        .USER_CLK      (USER_CLK),
        .SYSTEM_RESET_N(SYSTEM_RESET_N),
        .bus           (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Bit histories, oldest bit at index 0; taps are the bits received 39 and 58 bits ago.
    bit txq[$];
    bit rxq[$];
    int tx_slot;
    bit m_expect;
    int m_good, m_bad;
    bit m_locked;

    logic [63:0] e_data, e_orig;
    logic [1:0]  e_hdr;
    logic        e_vld, e_ctrl, e_mm;
    bit          e_loop, e_st;
    bit          loop_en, track;
    int          st_idx, lock_idx, mm_cnt;

    function automatic logic [57:0] q2vec(input bit q[$]);
        logic [57:0] v;
        for (int k = 0; k < 58; k++) v[k] = q[57-k];
        return v;
    endfunction

    task automatic model_reset();
        rxq.delete();
        repeat (58) rxq.push_back(1'b1);
        m_expect = 0; m_good = 0; m_bad = 0; m_locked = 0;
        e_data = '0; e_hdr = 2'b00; e_vld = 0; e_ctrl = 0; e_mm = 0; e_loop = 0; e_st = 0; e_orig = '0;
    endtask

    task automatic tx_reset();
        txq.delete();
        repeat (58) txq.push_back(1'b1);
        tx_slot = 0;
    endtask

    task automatic model_step(input logic [63:0] d, input logic [1:0] h, input logic v,
                              input logic pt, input int kind, input logic [63:0] orig);
        bit pass;
        e_hdr = h; e_vld = v; e_ctrl = 0; e_mm = 0; e_loop = 0; e_st = 0;
        if (pt) begin
            e_data = d;
            foreach (rxq[k]) rxq[k] = 1'b1;
            m_expect = 0; m_good = 0; m_bad = 0; m_locked = 0;
        end else if (v) begin
            if (m_expect) begin
                pass = (d[63:58] == 6'b001010) && (d[57:0] == q2vec(rxq));
                e_data = d; e_ctrl = 1; e_mm = !pass; e_st = 1;
                for (int k = 0; k < 58; k++) rxq[57-k] = d[k];
                m_expect = 0;
                if (!m_locked) begin
                    if (pass) begin
                        m_good = (m_good < 15) ? m_good + 1 : 15;
                        if (m_good == LOCK_N) begin m_locked = 1; m_bad = 0; end
                    end else m_good = 0;
                end else begin
                    if (pass) m_bad = 0;
                    else begin
                        m_bad = (m_bad < 15) ? m_bad + 1 : 15;
                        if (m_bad == LOSS_N) begin m_locked = 0; m_good = 0; end
                    end
                end
            end else if (d == SYNC && h == 2'b10) begin
                e_data = d; e_ctrl = 1; m_expect = 1;
            end else begin
                for (int i = 0; i < 64; i++) begin
                    e_data[i] = d[i] ^ rxq[19] ^ rxq[0];
                    rxq.push_back(d[i]);
                    void'(rxq.pop_front());
                end
                e_loop = loop_en && (kind == 0);
                e_orig = orig;
            end
        end
    endtask

    task automatic check_out();
        chk("data", bus.DATA_OUT, e_data);
        chk("hdr", 64'(bus.HEADER_OUT), 64'(e_hdr));
        chk("vld", 64'(bus.DATA_OUT_VALID), 64'(e_vld));
        chk("ctrl", 64'(bus.CTRL_WORD_OUT), 64'(e_ctrl));
        chk("mismatch", 64'(bus.STATE_MISMATCH), 64'(e_mm));
        chk("locked", 64'(bus.SCRAMBLER_LOCKED), 64'(m_locked));
        if (e_loop) chk("loopback", bus.DATA_OUT, e_orig);
        if (bus.STATE_MISMATCH) mm_cnt++;
        if (track && e_st) begin
            st_idx++;
            if (bus.SCRAMBLER_LOCKED && lock_idx == 0) lock_idx = st_idx;
            if (st_idx == 1) chk("first_state_word", bus.DATA_OUT, 64'h2BFFFFFFFFFFFFFF);
        end
    endtask

    task automatic cycle(input logic [63:0] d, input logic [1:0] h, input logic v,
                         input logic pt, input int kind, input logic [63:0] orig);
        @(negedge USER_CLK);
        check_out();
        bus.DATA_IN = d; bus.HEADER_IN = h; bus.DATA_IN_VALID = v; bus.PASSTHROUGH = pt;
        model_step(d, h, v, pt, kind, orig);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(64'h0, 2'b00, 1'b0, 1'b0, 0, 64'h0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, bus.DATA_OUT, 64'h0);
        chk({tag, "_hdr"}, 64'(bus.HEADER_OUT), 64'h0);
        chk({tag, "_vld"}, 64'(bus.DATA_OUT_VALID), 64'h0);
        chk({tag, "_ctrl"}, 64'(bus.CTRL_WORD_OUT), 64'h0);
        chk({tag, "_mm"}, 64'(bus.STATE_MISMATCH), 64'h0);
        chk({tag, "_lock"}, 64'(bus.SCRAMBLER_LOCKED), 64'h0);
    endtask

    task automatic drive_idle();
        bus.DATA_IN = '0; bus.HEADER_IN = 2'b00; bus.DATA_IN_VALID = 0; bus.PASSTHROUGH = 0;
    endtask

    task automatic do_reset();
        @(negedge USER_CLK);
        check_out();
        SYSTEM_RESET_N = 0;
        drive_idle();
        #1 chk_zero("rst");
        model_reset();
        tx_reset();
        @(negedge USER_CLK);
        SYSTEM_RESET_N = 1;
        model_step(64'h0, 2'b00, 1'b0, 1'b0, 0, 64'h0);
    endtask

    task automatic tx_word(output logic [63:0] d, output logic [1:0] h, output logic [63:0] orig, output int kind);
        bit b;
        orig = '0;
        if (tx_slot == 0) begin
            d = SYNC; h = 2'b10; kind = 1;
        end else if (tx_slot == 1) begin
            d = {6'b001010, q2vec(txq)}; h = 2'b10; kind = 2;
        end else begin
            case ($urandom_range(0, 3))
                0:       orig = 64'h0123456789ABCDEF;
                1:       orig = 64'h0;
                2:       orig = 64'hFFFFFFFFFFFFFFFF;
                default: orig = {$urandom, $urandom};
            endcase
            for (int i = 0; i < 64; i++) begin
                b = orig[i] ^ txq[19] ^ txq[0];
                d[i] = b;
                txq.push_back(b);
                void'(txq.pop_front());
            end
            h = 2'b01; kind = 0;
        end
        tx_slot = (tx_slot + 1) % 8;
    endtask

    task automatic tx_send(input int n, input int n_corrupt, input int bubble_pct, input logic pt);
        logic [63:0] d, orig;
        logic [1:0]  h;
        int          kind;
        int          left;
        left = n_corrupt;
        for (int i = 0; i < n; i++) begin
            if (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct)
                cycle({$urandom, $urandom}, 2'($urandom), 1'b0, pt, 0, 64'h0);
            tx_word(d, h, orig, kind);
            if (kind == 2 && left > 0) begin
                d[0] = ~d[0];
                left--;
            end
            cycle(d, h, 1'b1, pt, kind, orig);
            if (kind == 1 && bubble_pct > 0)
                repeat (2) cycle({$urandom, $urandom}, 2'($urandom), 1'b0, pt, 0, 64'h0);
        end
    endtask

    initial begin
        logic [63:0] d, orig;
        logic [1:0]  h;
        int          kind;
        drive_idle();
        model_reset();
        tx_reset();
        loop_en = 0; track = 0; st_idx = 0; lock_idx = 0; mm_cnt = 0;

        // Clean loopback from reset: lock on the 4th state word.
        do_reset();
        loop_en = 1; track = 1;
        tx_send(48, 0, 0, 1'b0);
        idle(1);
        track = 0;
        chk("lock_at_state_word", 64'(lock_idx), 64'd4);

        // Corrupted state words while locked.
        loop_en = 0; mm_cnt = 0;
        tx_send(16, 2, 0, 1'b0);
        tx_send(8, 0, 0, 1'b0);
        idle(1);
        chk("two_bad_keeps_lock", 64'(bus.SCRAMBLER_LOCKED), 64'd1);
        chk("two_bad_mm_count", 64'(mm_cnt), 64'd2);
        tx_send(16, 2, 0, 1'b0);
        idle(1);
        chk("bad_cnt_cleared", 64'(bus.SCRAMBLER_LOCKED), 64'd1);
        mm_cnt = 0;
        tx_send(24, 3, 0, 1'b0);
        idle(1);
        chk("three_bad_mm_count", 64'(mm_cnt), 64'd3);
        chk("three_bad_unlock", 64'(bus.SCRAMBLER_LOCKED), 64'd0);

        // Bad state-word prefix straight after reset.
        do_reset();
        mm_cnt = 0;
        tx_word(d, h, orig, kind);
        cycle(d, h, 1'b1, 1'b0, kind, orig);
        tx_word(d, h, orig, kind);
        cycle(64'h3BFFFFFFFFFFFFFF, 2'b10, 1'b1, 1'b0, 2, 64'h0);
        idle(1);
        chk("bad_prefix_mm", 64'(mm_cnt), 64'd1);
        loop_en = 1;
        tx_send(24, 0, 0, 1'b0);
        idle(1);
        chk("bad_prefix_no_early_lock", 64'(bus.SCRAMBLER_LOCKED), 64'd0);
        tx_send(8, 0, 0, 1'b0);
        idle(1);
        chk("bad_prefix_lock_4th", 64'(bus.SCRAMBLER_LOCKED), 64'd1);

        // Valid bubbles, including between sync and state words.
        do_reset();
        loop_en = 1;
        tx_send(64, 0, 30, 1'b0);
        idle(1);
        chk("gaps_locked", 64'(bus.SCRAMBLER_LOCKED), 64'd1);

        // Passthrough while locked, then relock from HUNT.
        loop_en = 0;
        tx_send(10, 0, 0, 1'b1);
        repeat (3) cycle({$urandom, $urandom}, 2'b01, 1'b0, 1'b1, 0, 64'h0);
        chk("pt_unlocked", 64'(bus.SCRAMBLER_LOCKED), 64'd0);
        tx_send(40, 0, 0, 1'b0);
        idle(1);
        chk("pt_relock", 64'(bus.SCRAMBLER_LOCKED), 64'd1);

        // Async reset between a sync word and its state word.
        do_reset();
        tx_send(8, 0, 0, 1'b0);
        tx_word(d, h, orig, kind);
        cycle(d, h, 1'b1, 1'b0, kind, orig);
        @(posedge USER_CLK);
        #3 SYSTEM_RESET_N = 0;
        #1 chk_zero("midrst");
        model_reset();
        @(negedge USER_CLK);
        SYSTEM_RESET_N = 1;
        drive_idle();
        model_step(64'h0, 2'b00, 1'b0, 1'b0, 0, 64'h0);
        tx_word(d, h, orig, kind);
        cycle(d, h, 1'b1, 1'b0, kind, orig);
        idle(1);
        chk("orphan_state_as_data", 64'(bus.CTRL_WORD_OUT), 64'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog simulation did not complete t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
